// File: rtl/lab_defs_pkg.sv
// Shared definitions for the lab ALU datapath:
// divider FSM encoding, default width and HI/LO opcodes.
package lab_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [3:0] MULT  = 4'b0110;
    localparam logic [3:0] MULTU = 4'b0111;
    localparam logic [3:0] DIV   = 4'b1110;
    localparam logic [3:0] DIVU  = 4'b1111;

endpackage

// File: rtl/lab5_cond_neg.sv
// Conditional two's-complement: y = neg ? -x : x.
// Used for operand magnitudes and for result sign fixup.
module lab5_cond_neg #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/lab5_div_unit.sv
// Multi-cycle restoring divider producing quotient in lo and
// remainder in hi, signed or unsigned.
module lab5_div_unit
    import lab_defs::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t state, state_nx;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] a_raw, dvs;
    logic [WIDTH-1:0] rem, quo;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic             qneg, rneg, zq;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sh, trial;
    logic             b_zero;

    assign b_zero = (b == '0);

    lab5_cond_neg #(.WIDTH(WIDTH)) u_abs_a (
        .neg (sign & a[WIDTH-1]),
        .x   (a),
        .y   (a_mag)
    );

    lab5_cond_neg #(.WIDTH(WIDTH)) u_abs_b (
        .neg (sign & b[WIDTH-1]),
        .x   (b),
        .y   (b_mag)
    );

    lab5_cond_neg #(.WIDTH(WIDTH)) u_fix_q (
        .neg (qneg),
        .x   (quo),
        .y   (q_fix)
    );

    lab5_cond_neg #(.WIDTH(WIDTH)) u_fix_r (
        .neg (rneg),
        .x   (rem),
        .y   (r_fix)
    );

    // rem < dvs always holds, so bit WIDTH of trial is the borrow
    assign sh    = {rem, quo[WIDTH-1]};
    assign trial = sh - {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = b_zero ? FIX : RUN;
            RUN:  if (cnt == CW'(1)) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
            a_raw    <= '0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            zq       <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= (state == DONE);
            if (state == IDLE && start) begin
                busy <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_raw    <= a;
                        dvs      <= b_mag;
                        quo      <= a_mag;
                        rem      <= '0;
                        qneg     <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg     <= sign & a[WIDTH-1];
                        zq       <= b_zero;
                        div_zero <= 1'b0;
                        cnt      <= CW'(WIDTH);
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= sh[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    if (zq) begin
                        lo       <= '1;
                        hi       <= a_raw;
                        div_zero <= 1'b1;
                    end else begin
                        lo <= q_fix;
                        hi <= r_fix;
                    end
                end
                DONE: ;
            endcase
        end
    end

endmodule
